// File: rtl/fpu_hp_wb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_hp_wb_sequencer_if
// Description : Wishbone slave bus, FPU issue/response and IRQ signals
//               bundled for the half-precision FPU command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_hp_wb_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [15:0] fpu_opa_o;
    logic [15:0] fpu_opb_o;
    logic [3:0]  fpu_op_o;
    logic [2:0]  fpu_rm_o;
    logic        fpu_valid_o;
    logic [15:0] fpu_result_i;
    logic [4:0]  fpu_flags_i;
    logic        fpu_done_i;
    logic        irq_o;

    // Sequencer side
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  fpu_result_i, fpu_flags_i, fpu_done_i,
        output wbs_ack_o, wbs_dat_o,
        output fpu_opa_o, fpu_opb_o, fpu_op_o, fpu_rm_o, fpu_valid_o,
        output irq_o
    );

    // SoC / FPU-core side
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output fpu_result_i, fpu_flags_i, fpu_done_i,
        input  wbs_ack_o, wbs_dat_o,
        input  fpu_opa_o, fpu_opb_o, fpu_op_o, fpu_rm_o, fpu_valid_o,
        input  irq_o
    );
endinterface
`default_nettype wire

// File: rtl/fpu_hp_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_hp_wb_sequencer
// Description : Wishbone-controlled command sequencer for the half-precision
//               FPU. Holds operand/opcode/rounding registers, issues one
//               operation at a time, waits for done with a timeout, captures
//               result and flags and raises a level IRQ on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_hp_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  wire logic            wb_clk_i,
    input  wire logic            wb_rst_i,
    fpu_hp_wb_sequencer_if.slave bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               w_set_done, w_set_tmo;

    logic        r_ack;
    logic [31:0] r_dat, w_rdata;
    logic [15:0] r_opa, r_opb, r_result;
    logic [3:0]  r_op, w_op_new;
    logic [2:0]  r_rm, w_rm_new;
    logic        r_irq_en, r_done, r_timeout, r_overrun, r_irq;
    logic [4:0]  r_flags;
    logic [15:0] r_fpu_opa, r_fpu_opb;
    logic [3:0]  r_fpu_op;
    logic [2:0]  r_fpu_rm;

    // Bus decode: every request is acked, only in-range offsets 0..4 act
    wire       w_req       = bus.wbs_stb_i & bus.wbs_cyc_i & ~r_ack;
    wire       w_hit       = (bus.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    wire [2:0] w_off       = bus.wbs_adr_i[4:2];
    wire       w_wr        = w_req & bus.wbs_we_i & w_hit;
    wire       w_wr_opa    = w_wr & (w_off == 3'd0);
    wire       w_wr_opb    = w_wr & (w_off == 3'd1);
    wire       w_wr_ctrl   = w_wr & (w_off == 3'd2);
    wire       w_wr_stat   = w_wr & (w_off == 3'd3);
    wire       w_busy      = (r_state != c_IDLE);
    wire       w_start_req = w_wr_ctrl & bus.wbs_sel_i[3] & bus.wbs_dat_i[31];
    wire       w_start     = w_start_req & ~w_busy;
    wire       w_ovr_set   = w_start_req & w_busy;
    wire       w_w1c       = w_wr_stat & bus.wbs_sel_i[0];
    wire       w_unused    = ^{bus.wbs_adr_i[1:0], bus.wbs_dat_i[30:16], bus.wbs_sel_i[2]};

    // The opcode/rounding mode written together with a start are the ones issued
    assign w_op_new = (w_wr_ctrl & bus.wbs_sel_i[0]) ? bus.wbs_dat_i[3:0] : r_op;
    assign w_rm_new = (w_wr_ctrl & bus.wbs_sel_i[0]) ? bus.wbs_dat_i[6:4] : r_rm;

    // Read-back multiplexer; unmapped offsets and foreign addresses read 0
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                3'd0:    w_rdata = {16'b0, r_opa};
                3'd1:    w_rdata = {16'b0, r_opb};
                3'd2:    w_rdata = {23'b0, r_irq_en, 1'b0, r_rm, r_op};
                3'd3:    w_rdata = {23'b0, r_flags, r_overrun, r_timeout, r_done, w_busy};
                3'd4:    w_rdata = {16'b0, r_result};
                default: w_rdata = '0;
            endcase
        end
    end

    // Single-cycle registered acknowledge with read data captured at request
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rdata : '0;
        end
    end

    // Software-visible operand and control registers with byte enables
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_op     <= '0;
            r_rm     <= '0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_opa & bus.wbs_sel_i[0]) r_opa[7:0]  <= bus.wbs_dat_i[7:0];
            if (w_wr_opa & bus.wbs_sel_i[1]) r_opa[15:8] <= bus.wbs_dat_i[15:8];
            if (w_wr_opb & bus.wbs_sel_i[0]) r_opb[7:0]  <= bus.wbs_dat_i[7:0];
            if (w_wr_opb & bus.wbs_sel_i[1]) r_opb[15:8] <= bus.wbs_dat_i[15:8];
            r_op <= w_op_new;
            r_rm <= w_rm_new;
            if (w_wr_ctrl & bus.wbs_sel_i[1]) r_irq_en <= bus.wbs_dat_i[8];
        end
    end

    // FSM state and wait-counter registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state: done beats the timeout when both land on the last cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_set_done  = 1'b0;
        w_set_tmo   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) w_state_nxt = c_ISSUE;
            end
            c_ISSUE: begin
                w_state_nxt = c_WAIT;
                w_cnt_nxt   = '0;
            end
            c_WAIT: begin
                if (bus.fpu_done_i) begin
                    w_state_nxt = c_IDLE;
                    w_set_done  = 1'b1;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_set_tmo   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Issue latches: frozen for the whole operation
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_fpu_opa <= '0;
            r_fpu_opb <= '0;
            r_fpu_op  <= '0;
            r_fpu_rm  <= '0;
        end else if (w_start) begin
            r_fpu_opa <= r_opa;
            r_fpu_opb <= r_opb;
            r_fpu_op  <= w_op_new;
            r_fpu_rm  <= w_rm_new;
        end
    end

    // Status, result and flags; a set beats a same-edge W1C clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
            r_flags   <= '0;
            r_result  <= '0;
        end else begin
            if (w_set_done) begin
                r_done   <= 1'b1;
                r_result <= bus.fpu_result_i;
                r_flags  <= bus.fpu_flags_i;
            end else if (w_start | (w_w1c & bus.wbs_dat_i[1])) begin
                r_done <= 1'b0;
            end
            if (w_set_tmo)                                     r_timeout <= 1'b1;
            else if (w_start | (w_w1c & bus.wbs_dat_i[2]))     r_timeout <= 1'b0;
            if (w_ovr_set)                                     r_overrun <= 1'b1;
            else if (w_w1c & bus.wbs_dat_i[3])                 r_overrun <= 1'b0;
        end
    end

    // Registered level interrupt
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_irq <= 1'b0;
        else          r_irq <= r_irq_en & (r_done | r_timeout);
    end

    assign bus.wbs_ack_o   = r_ack;
    assign bus.wbs_dat_o   = r_dat;
    assign bus.fpu_opa_o   = r_fpu_opa;
    assign bus.fpu_opb_o   = r_fpu_opb;
    assign bus.fpu_op_o    = r_fpu_op;
    assign bus.fpu_rm_o    = r_fpu_rm;
    assign bus.fpu_valid_o = (r_state == c_ISSUE);
    assign bus.irq_o       = r_irq;
endmodule
`default_nettype wire
